// File: rtl/serial_sub_pkg.sv
// Shared constants and FSM encoding for the bit-serial subtractor.
// Holds the default operand width, the widest supported width and the bit-counter width.
// Imported by serial_sub64; carries no logic of its own.
package serial_sub_pkg;

  localparam int SUB_WIDTH_DEFAULT = 64;
  localparam int SUB_WIDTH_MAX     = 64;
  localparam int SUB_CNT_W         = $clog2(SUB_WIDTH_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_e;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow-out.
// Purely combinational, zero latency.
// No flow control; the enclosing FSM decides when the cell's outputs are consumed.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic a_xor_b;

  assign a_xor_b = a ^ b;
  assign d       = a_xor_b ^ bin;
  assign bout    = (~a & b) | (~a_xor_b & bin);

endmodule

// File: rtl/serial_sub64.sv
// Bit-serial unsigned subtractor (diff = a - b mod 2^WIDTH), one bit per clock, LSB first.
// Latency WIDTH cycles from accept to out_valid; one result per WIDTH+2 cycles.
// in_ready only in IDLE; result held in DONE until out_ready. Define SUB_OVF_EN for the overflow port.
module serial_sub64
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SUB_OVF_EN
  ,
  output logic             overflow
`endif
);

  sub_state_e           state_q;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic [WIDTH-1:0]     diff_q;
  logic                 borrow_q;
  logic [SUB_CNT_W-1:0] cnt_q;
  logic                 in_ready_q;
  logic                 out_valid_q;

  logic                 bit_d;
  logic                 borrow_d;
  logic [WIDTH-1:0]     diff_d;
  logic                 last_bit;
  logic                 accept;

  // The single subtractor cell always looks at the current LSBs and the running borrow.
  full_subtractor u_fs (
    .a   (a_q[0]),
    .b   (b_q[0]),
    .bin (borrow_q),
    .d   (bit_d),
    .bout(borrow_d)
  );

  // New result bits enter at the MSB so that after WIDTH shifts bit 0 sits at diff[0].
  assign diff_d   = {bit_d, diff_q[WIDTH-1:1]};
  assign last_bit = (cnt_q == SUB_CNT_W'(WIDTH - 1));
  assign accept   = (state_q == IDLE) && in_valid && in_ready_q;

  // Control FSM plus datapath registers; handshake outputs come straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      diff_q      <= '0;
      borrow_q    <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q        <= a;
            b_q        <= b;
            borrow_q   <= 1'b0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          a_q      <= a_q >> 1;
          b_q      <= b_q >> 1;
          diff_q   <= diff_d;
          borrow_q <= borrow_d;
          cnt_q    <= cnt_q + SUB_CNT_W'(1);
          if (last_bit) begin
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign borrow    = borrow_q;

`ifdef SUB_OVF_EN
  logic a_msb_q;
  logic b_msb_q;

  // The operand shift registers lose their MSBs while running, so keep the sign bits aside.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
    end else if (accept) begin
      a_msb_q <= a[WIDTH-1];
      b_msb_q <= b[WIDTH-1];
    end
  end

  // Signed overflow: operands of differing sign and a result whose sign departs from the minuend.
  assign overflow = out_valid_q & (a_msb_q ^ b_msb_q) & (diff_q[WIDTH-1] ^ a_msb_q);
`endif

endmodule

// File: tb/tb_serial_sub64.sv
// Directed bench for serial_sub64 at the default width of 64.
// Checks reset state, latency, results, DONE hold behaviour and mid-run reset.
// Overflow checks are compiled in only when SUB_OVF_EN is defined.
module tb_serial_sub64;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         borrow;
`ifdef SUB_OVF_EN
  logic         overflow;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  serial_sub64 #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff     (diff),
    .borrow   (borrow)
`ifdef SUB_OVF_EN
    ,
    .overflow (overflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Wait (bounded) for out_valid; returns the number of rising edges waited.
  task automatic wait_result(output int cyc);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Full transaction with out_ready held high; starts and ends on a negedge.
  task automatic run_op(input string tag, input logic [63:0] av, input logic [63:0] bv,
                        input logic [63:0] exp_d, input logic exp_b, input logic exp_o);
    int cyc;
    check({tag, ".rdy_before"}, in_ready, 1);
    a = av; b = bv; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; a = '0; b = '0;
    check({tag, ".rdy_run"}, in_ready, 0);
    wait_result(cyc);
    check({tag, ".latency"}, cyc, W);
    check({tag, ".diff"}, diff, exp_d);
    check({tag, ".borrow"}, borrow, exp_b);
`ifdef SUB_OVF_EN
    check({tag, ".ovf"}, overflow, exp_o);
`endif
    @(negedge clk);
    check({tag, ".vld_after"}, out_valid, 0);
    check({tag, ".rdy_after"}, in_ready, 1);
  endtask

  initial begin
    int cyc;
    int seen;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("rst.out_valid", out_valid, 0);
    check("rst.diff", diff, 0);
    check("rst.borrow", borrow, 0);
`ifdef SUB_OVF_EN
    check("rst.ovf", overflow, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    check("rst.in_ready", in_ready, 1);

    // Basic vectors, including equal operands, wrap-around and signed overflow cases.
    run_op("10m3",   64'd10, 64'd3, 64'd7, 1'b0, 1'b0);
    run_op("0m1",    64'd0,  64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    run_op("min_m1", 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
    run_op("eq",     64'hDEAD_BEEF_0000_1234, 64'hDEAD_BEEF_0000_1234, 64'd0, 1'b0, 1'b0);
    run_op("3m10",   64'd3, 64'd10, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1, 1'b0);
    run_op("pat",    64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                     64'h0246_8ACF_1357_9BDF, 1'b1, 1'b0);
    run_op("max_m0", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    run_op("maxp_m1",64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                     64'h8000_0000_0000_0000, 1'b1, 1'b1);

    // Hold in DONE with out_ready low while in_valid toggles with fresh operands.
    a = 64'd100; b = 64'd1; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_result(cyc);
    check("hold.latency", cyc, W);
    for (int i = 0; i < 10; i++) begin
      in_valid = ~in_valid;
      a = 64'(i) * 64'd7 + 64'd1000;
      b = 64'(i);
      @(posedge clk);
      @(negedge clk);
      check("hold.out_valid", out_valid, 1);
      check("hold.in_ready", in_ready, 0);
      check("hold.diff", diff, 64'd99);
      check("hold.borrow", borrow, 0);
    end
    in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    @(negedge clk);
    check("hold.release_vld", out_valid, 0);
    check("hold.release_rdy", in_ready, 1);
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1 || in_ready !== 1'b1) seen++;
    end
    check("hold.no_capture", seen, 0);

    // Reset in the middle of a run: the operation must vanish.
    a = 64'hFFFF_0000_FFFF_0000; b = 64'h0000_FFFF_0000_FFFF; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (30) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst.out_valid", out_valid, 0);
    check("midrst.diff", diff, 0);
    check("midrst.borrow", borrow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst.in_ready", in_ready, 1);
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    check("midrst.no_result", seen, 0);
    run_op("5m5", 64'd5, 64'd5, 64'd0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_sub64.md
SERIAL_SUB64 -- requirements
Module: serial_sub64

Interface
REQ-001 Parameter WIDTH, default 64, operand and result width in bits; legal range 2..64.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  operand pair a/b present.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 a  input  WIDTH  minuend, unsigned.
REQ-007 b  input  WIDTH  subtrahend, unsigned.
REQ-008 out_valid  output  1  diff/borrow valid and held.
REQ-009 out_ready  input  1  consumer takes the result.
REQ-010 diff  output  WIDTH  a - b modulo 2^WIDTH.
REQ-011 borrow  output  1  final borrow-out; 1 iff a < b unsigned.
REQ-012 overflow  output  1  signed overflow; present only with SUB_OVF_EN.

Function
REQ-013 Bit-serial subtraction: one bit per clock, LSB first, via one full-subtractor cell and a 1-bit borrow register.
REQ-014 FSM states: IDLE, RUN, DONE; encoding is the package enum.
REQ-015 IDLE: in_ready=1; on in_valid&in_ready at edge T, capture a and b into shift registers, clear borrow register and bit counter, go RUN.
REQ-016 RUN: each edge computes d=a0^b0^bin and bout=(~a0&b0)|(~(a0^b0)&bin), shifts d into diff from the MSB end, increments counter.
REQ-017 RUN -> DONE on the edge that processes bit WIDTH-1; out_valid rises at edge T+WIDTH (latency WIDTH cycles from accept).
REQ-018 DONE: out_valid=1, diff/borrow/overflow stable; on out_valid&out_ready go IDLE at that edge.
REQ-019 in_ready=0 in RUN and DONE; in_valid there is ignored, no operand is captured.
REQ-020 out_valid=0 in IDLE and RUN; diff is not qualified while out_valid=0.
REQ-021 Combinational paths in_valid->in_ready and out_ready->out_valid are forbidden.
REQ-022 a==b yields diff=0, borrow=0; a<b yields wrapped diff and borrow=1.
REQ-023 Back-to-back: after DONE->IDLE, the next accept occurs no earlier than the following edge; throughput is one result per WIDTH+2 cycles.

Reset
REQ-024 rst_n low forces state IDLE, in_ready=1 after release, out_valid=0, diff=0, borrow=0, overflow=0, counter=0.
REQ-025 Reset asserted in RUN or DONE discards the operation; no result is presented after release.

Configuration
REQ-026 Macro SUB_OVF_EN defined: overflow port exists and in DONE equals (a[MSB]!=b[MSB]) & (diff[MSB]!=a[MSB]) using the captured a/b MSBs.
REQ-027 SUB_OVF_EN undefined: overflow port and its MSB capture registers are absent; all other behaviour identical.

Structure
REQ-028 Package serial_sub_pkg holds the FSM state enum, default WIDTH constant, and counter-width constant ($clog2 of max WIDTH).
REQ-029 One sub-module full_subtractor (inputs a, b, bin; outputs d, bout), gate-level, instantiated once.

Verification
REQ-030 a=64'd10, b=64'd3, out_ready=1 -> out_valid exactly 64 cycles after accept, diff=7, borrow=0, then in_ready=1 next cycle.
REQ-031 a=0, b=1 -> diff=64'hFFFF_FFFF_FFFF_FFFF, borrow=1; SUB_OVF_EN: overflow=0.
REQ-032 SUB_OVF_EN, a=64'h8000_0000_0000_0000, b=1 -> diff=64'h7FFF_FFFF_FFFF_FFFF, overflow=1, borrow=0.
REQ-033 out_ready held 0 for 10 cycles in DONE, in_valid toggled with new operands -> result stable, no new capture, in_ready=0 throughout.
REQ-034 rst_n pulsed low at bit 30 of RUN -> out_valid stays 0, outputs 0, next operation a=5,b=5 gives diff=0, borrow=0.
